// File: rtl/nn_acc_pkg.sv
// Shared definitions for the accelerator SRAM read path: default widths and
// the stream-reader FSM encoding.
package nn_acc_pkg;

    localparam int unsigned SRD_ADDR_WIDTH = 10;
    localparam int unsigned SRD_DATA_WIDTH = 256;

    typedef enum logic {
        SRD_IDLE = 1'b0,
        SRD_RUN  = 1'b1
    } srd_state_e;

endpackage

// File: rtl/sram_rd_ostage.sv
// Registered output stage of the SRAM stream reader: captures a fetched word and
// holds it on the stream until the consumer accepts it.
module sram_rd_ostage
    import nn_acc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SRD_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  last_q;

    // A load always wins: the reader only fetches when the slot is empty or draining.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= load_data;
            last_q  <= load_last;
        end else if (valid_q && m_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign m_valid = valid_q;
    assign m_data  = data_q;
    assign m_last  = last_q;

endmodule

// File: rtl/sram_stream_reader.sv
// Streams num_words consecutive SRAM words from base_addr onto a valid/ready port.
// Optional multi-pass replay is enabled by defining SRAM_RD_LOOP_EN (adds num_loops).
module sram_stream_reader
    import nn_acc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SRD_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = SRD_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    output logic                  busy,
    output logic                  done,
    output logic                  enb,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] doutb,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
`ifdef SRAM_RD_LOOP_EN
    ,
    input  logic [7:0]            num_loops
`endif
);

    localparam logic [ADDR_WIDTH:0] LEFT_ONE = (ADDR_WIDTH + 1)'(1);

    srd_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   left_q, left_d;
    logic                  done_q, done_d;
    logic                  slot_free;
    logic                  fetch;
    logic                  last_fetch;

`ifdef SRAM_RD_LOOP_EN
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   num_q, num_d;
    logic [7:0]            loops_q, loops_d;
`endif

    assign slot_free  = !m_valid || m_ready;
    assign fetch      = (state_q == SRD_RUN) && (left_q != '0) && slot_free;
    assign last_fetch = (left_q == LEFT_ONE);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        done_d  = 1'b0;
`ifdef SRAM_RD_LOOP_EN
        base_d  = base_q;
        num_d   = num_q;
        loops_d = loops_q;
`endif
        case (state_q)
            SRD_IDLE: begin
                if (start) begin
                    state_d = SRD_RUN;
                    addr_d  = base_addr;
                    left_d  = num_words;
`ifdef SRAM_RD_LOOP_EN
                    base_d  = base_addr;
                    num_d   = num_words;
                    // loops_q counts passes still to run after the current one
                    loops_d = (num_loops == 8'd0) ? 8'd0 : num_loops - 8'd1;
`endif
                end
            end
            SRD_RUN: begin
                if (fetch) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    left_d = left_q - LEFT_ONE;
`ifdef SRAM_RD_LOOP_EN
                    if (last_fetch && loops_q != 8'd0) begin
                        addr_d  = base_q;
                        left_d  = num_q;
                        loops_d = loops_q - 8'd1;
                    end
`endif
                end else if (left_q == '0 && slot_free) begin
                    state_d = SRD_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = SRD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SRD_IDLE;
            addr_q  <= '0;
            left_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            done_q  <= done_d;
        end
    end

`ifdef SRAM_RD_LOOP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q  <= '0;
            num_q   <= '0;
            loops_q <= 8'd0;
        end else begin
            base_q  <= base_d;
            num_q   <= num_d;
            loops_q <= loops_d;
        end
    end
`endif

    assign busy  = (state_q == SRD_RUN);
    assign done  = done_q;
    assign enb   = fetch;
    assign addrb = addr_q;

    sram_rd_ostage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ostage (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (fetch),
        .load_data (doutb),
        .load_last (last_fetch),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last)
    );

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed, table-driven bench for sram_stream_reader with a behavioural async-read SRAM.
module tb_sram_stream_reader;

    localparam int AW = 10;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_words = '0;
    logic          busy, done, enb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
`ifdef SRAM_RD_LOOP_EN
    logic [7:0]    num_loops = 8'd1;
`endif

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem [1024];

    always #5 clk = ~clk;

    assign doutb = mem[addrb];

    sram_stream_reader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .enb       (enb),
        .addrb     (addrb),
        .doutb     (doutb),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
`ifdef SRAM_RD_LOOP_EN
        ,
        .num_loops (num_loops)
`endif
    );

    function automatic logic [DW-1:0] word_of(input int a);
        logic [31:0] w;
        w = 32'hC0DE_0000 ^ (32'(a) * 32'h0001_0003);
        return {w, ~w, w ^ 32'h5A5A_5A5A, w, ~w, w, w ^ 32'hFFFF_0000, w};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] base;
        int            num;
        int            loops;
        logic [31:0]   stall;    // bit c set: m_ready low in cycle c
        int            restart;  // cycle in which a spurious start is driven, -1 for none
        int            exp_done;
        string         name;
    } vec_t;

    // Start in cycle 0; walk cycles, checking addresses, beats, stalls and the done cycle.
    task automatic run_xfer(input vec_t v);
        int          c, got, nf, donec, n, nl, beats, limit;
        logic [AW-1:0] ea;
        n     = v.num;
        nl    = 1;
`ifdef SRAM_RD_LOOP_EN
        nl        = (v.loops == 0) ? 1 : v.loops;
        num_loops = 8'(v.loops);
`endif
        beats = n * nl;
        limit = v.exp_done + 8;
        got   = 0;
        nf    = 0;
        donec = -1;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = v.base;
        num_words = 11'(n);
        m_ready   = 1'b1;
        c = 1;
        while (c <= limit && donec < 0) begin
            @(posedge clk); #1;
            start = (c == v.restart);
            if (c == v.restart) begin
                base_addr = 10'h123;
                num_words = 11'd7;
            end
            m_ready = (c < 32) ? !v.stall[c] : 1'b1;
            @(negedge clk);
            if (enb) begin
                if (n == 0) begin
                    check({v.name, " enb_on_empty"}, DW'(enb), DW'(0));
                end else begin
                    ea = v.base + AW'(nf % n);
                    check({v.name, " addrb"}, DW'(addrb), DW'(ea));
                    nf++;
                end
            end
            if (m_valid && !m_ready)
                check({v.name, " enb_stalled"}, DW'(enb), DW'(0));
            if (m_valid && m_ready) begin
                if (got >= beats) begin
                    check({v.name, " extra_beat"}, DW'(m_valid), DW'(0));
                end else begin
                    ea = v.base + AW'(got % n);
                    check({v.name, " m_data"}, m_data, word_of(int'(ea)));
                    check({v.name, " m_last"}, DW'(m_last), DW'((got % n) == n - 1));
                end
                got++;
            end
            if (done) begin
                donec = c;
                check({v.name, " busy_at_done"}, DW'(busy), DW'(0));
            end else begin
                check({v.name, " busy"}, DW'(busy), DW'(1));
            end
            c++;
        end
        check({v.name, " done_cycle"}, DW'(donec), DW'(v.exp_done));
        check({v.name, " beat_count"}, DW'(got), DW'(beats));
        @(posedge clk); #1;
        start   = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        check({v.name, " idle_after"}, DW'({done, busy, m_valid}), DW'(0));
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{10'h010, 4,    1, 32'h0,       -1, 6,    "basic"};
        vecs[1] = '{10'h010, 4,    1, 32'h38,      -1, 9,    "stall3to5"};
        vecs[2] = '{10'h3FE, 4,    1, 32'h0,       -1, 6,    "wrap"};
        vecs[3] = '{10'h000, 0,    1, 32'h0,       -1, 2,    "empty"};
        vecs[4] = '{10'h100, 1,    1, 32'h0,       -1, 3,    "single"};
        vecs[5] = '{10'h200, 5,    1, 32'h14,      -1, 9,    "stall2_4"};
        vecs[6] = '{10'h080, 6,    1, 32'h0,       3,  8,    "restart_ignored"};

        for (int i = 0; i < 1024; i++) mem[i] = word_of(i);

        // Asynchronous reset values
        #1 reset_n = 1'b0;
        #2;
        check("rst_busy",    DW'(busy),    DW'(0));
        check("rst_done",    DW'(done),    DW'(0));
        check("rst_enb",     DW'(enb),     DW'(0));
        check("rst_addrb",   DW'(addrb),   DW'(0));
        check("rst_m_valid", DW'(m_valid), DW'(0));
        check("rst_m_last",  DW'(m_last),  DW'(0));
        check("rst_m_data",  m_data,       DW'(0));
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) run_xfer(vecs[i]);

        // Largest pass: the whole address space, starting one below the wrap point
        run_xfer('{10'h3FF, 1024, 1, 32'h0, -1, 1026, "full_space"});

        // Reset in the middle of a transfer
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = 10'h040;
        num_words = 11'd8;
        m_ready   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        check("pre_rst_valid", DW'(m_valid), DW'(1));
        reset_n = 1'b0;
        #1;
        check("midrst_valid", DW'(m_valid), DW'(0));
        check("midrst_busy",  DW'(busy),    DW'(0));
        check("midrst_enb",   DW'(enb),     DW'(0));
        check("midrst_addrb", DW'(addrb),   DW'(0));
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", DW'({done, busy, m_valid}), DW'(0));
        @(negedge clk);
        check("post_rst_nodone", DW'(done), DW'(0));

        run_xfer('{10'h050, 3, 1, 32'h0, -1, 5, "after_reset"});

`ifdef SRAM_RD_LOOP_EN
        run_xfer('{10'h020, 3, 2, 32'h0,  -1, 8,  "loop2"});
        run_xfer('{10'h030, 2, 0, 32'h0,  -1, 4,  "loop0"});
        run_xfer('{10'h3FF, 2, 3, 32'h10, -1, 9,  "loop3_stall"});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
